// File: rtl/fft_pkg.sv
// fft_pkg: issuer state encoding and counter width helper
package fft_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/fft_issuer_fifo.sv
// fft_issuer_fifo: synchronous result FIFO with occupancy count, full and empty flags
module fft_issuer_fifo
    import fft_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
)(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_push,
    input  logic [WIDTH-1:0]                i_data,
    input  logic                            i_pop,
    output logic [WIDTH-1:0]                o_data,
    output logic [cnt_width(DEPTH+1)-1:0]   o_count,
    output logic                            o_full,
    output logic                            o_empty
);
    localparam int PW = cnt_width(DEPTH);
    localparam int CW = cnt_width(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign o_count = r_count;
    assign o_empty = r_count == '0;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_data  = r_mem[r_rd];
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
            if (w_pop) r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/fft_twiddle_issuer.sv
// fft_twiddle_issuer: issues frame samples with twiddle indices to a multiplier and buffers results in order; FFT_ISSUER_LAST_CHECK_EN adds err_frame
module fft_twiddle_issuer
    import fft_pkg::*;
#(
    parameter int SIZE_DATA_FI  = 4,
    parameter int DATA_FFT_SIZE = 16,
    parameter int MULT_LATENCY  = 4,
    parameter int FIFO_DEPTH    = 8
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               stage,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_FFT_SIZE-1:0] s_data_i,
    input  logic [DATA_FFT_SIZE-1:0] s_data_q,
    input  logic                     s_last,
    output logic                     mul_en,
    output logic [DATA_FFT_SIZE-1:0] mul_data_i,
    output logic [DATA_FFT_SIZE-1:0] mul_data_q,
    output logic [15:0]              mul_fi_deg,
    input  logic                     mul_valid,
    input  logic [DATA_FFT_SIZE-1:0] mul_res_i,
    input  logic [DATA_FFT_SIZE-1:0] mul_res_q,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_FFT_SIZE-1:0] m_data_i,
    output logic [DATA_FFT_SIZE-1:0] m_data_q,
    output logic                     m_last,
    output logic                     busy
`ifdef FFT_ISSUER_LAST_CHECK_EN
    ,
    output logic                     err_frame
`endif
);
    localparam int HALF = 2 ** (SIZE_DATA_FI - 1);
    localparam int KW   = SIZE_DATA_FI - 1;
    localparam int CW   = cnt_width(FIFO_DEPTH + 1);
    localparam int UW   = CW + 2;
    localparam int IW   = cnt_width(MULT_LATENCY + 1);
    localparam int FW   = 2 * DATA_FFT_SIZE + 1;

    state_t                  r_state;
    state_t                  w_next;
    logic [KW-1:0]           r_k;
    logic [3:0]              r_stage;
    logic [CW-1:0]           r_in_flight;
    logic [MULT_LATENCY-1:0] r_last_sr;
    logic [IW-1:0]           r_ign;
    logic                    r_mul_last;
    logic                    w_hs;
    logic                    w_k_last;
    logic                    w_res_valid;
    logic                    w_fifo_empty;
    logic                    w_fifo_full;
    logic [CW-1:0]           w_fifo_count;
    logic [UW-1:0]           w_used;
    logic [15:0]             w_fi;
    logic [FW-1:0]           w_fifo_out;

    assign w_k_last    = r_k == KW'(HALF - 1);
    assign w_hs        = s_valid && s_ready;
    assign w_res_valid = mul_valid && (r_ign == '0);
    assign w_fi        = 16'((32'(r_k) << r_stage) & 32'(HALF - 1));
    // the sample registered for issue this cycle already owns a FIFO slot
    assign w_used      = UW'(r_in_flight) + UW'(w_fifo_count) + UW'(mul_en);
    assign s_ready     = (r_state == RUN) && (w_used < UW'(FIFO_DEPTH)) && !w_fifo_full;
    assign busy        = r_state != IDLE;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = s_valid ? RUN : IDLE;
            RUN:     w_next = (w_hs && w_k_last) ? DRAIN : RUN;
            DRAIN:   w_next = (r_in_flight == '0 && w_fifo_empty && !mul_en) ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    // r_ign masks late multiplier strobes from work issued before a reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_stage     <= '0;
            r_in_flight <= '0;
            r_last_sr   <= '0;
            r_ign       <= IW'(MULT_LATENCY);
            r_mul_last  <= 1'b0;
            mul_en      <= 1'b0;
            mul_data_i  <= '0;
            mul_data_q  <= '0;
            mul_fi_deg  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && s_valid) r_stage <= stage;
            if (w_hs) r_k <= w_k_last ? '0 : r_k + KW'(1);
            mul_en <= w_hs;
            if (w_hs) begin
                mul_data_i <= s_data_i;
                mul_data_q <= s_data_q;
                mul_fi_deg <= w_fi;
                r_mul_last <= w_k_last;
            end
            r_in_flight <= r_in_flight + CW'(mul_en) - CW'(w_res_valid);
            r_last_sr   <= (r_last_sr << 1) | MULT_LATENCY'(mul_en && r_mul_last);
            if (r_ign != '0) r_ign <= r_ign - IW'(1);
        end
    end

    fft_issuer_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .i_push (w_res_valid),
        .i_data ({r_last_sr[MULT_LATENCY-1], mul_res_i, mul_res_q}),
        .i_pop  (m_ready),
        .o_data (w_fifo_out),
        .o_count(w_fifo_count),
        .o_full (w_fifo_full),
        .o_empty(w_fifo_empty)
    );

    assign m_valid  = !w_fifo_empty;
    assign m_data_i = w_fifo_out[FW-2:DATA_FFT_SIZE];
    assign m_data_q = w_fifo_out[DATA_FFT_SIZE-1:0];
    assign m_last   = w_fifo_out[FW-1] && !w_fifo_empty;

`ifdef FFT_ISSUER_LAST_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_frame <= 1'b0;
        else if (w_hs && (s_last != w_k_last)) err_frame <= 1'b1;
    end
`else
    logic w_unused_last;
    assign w_unused_last = s_last;
`endif
endmodule

// File: tb/tb_fft_twiddle_issuer.sv
// tb_fft_twiddle_issuer: directed frames checked against a queue model of issue order, twiddle indices and result order
module tb_fft_twiddle_issuer;
    localparam int L    = 4;
    localparam int HALF = 8;

    typedef struct {
        logic [15:0] d_i;
        logic [15:0] d_q;
        logic [15:0] fi;
        logic        last;
        int          hs;
        bit          lat;
    } item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  stage = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data_i = '0;
    logic [15:0] s_data_q = '0;
    logic        s_last = 1'b0;
    logic        mul_en;
    logic [15:0] mul_data_i, mul_data_q, mul_fi_deg;
    logic        mul_valid;
    logic [15:0] mul_res_i, mul_res_q;
    logic        m_valid, m_ready, m_last, busy;
    logic [15:0] m_data_i, m_data_q;
`ifdef FFT_ISSUER_LAST_CHECK_EN
    logic        err_frame;
`endif
    logic        mr_en = 1'b1;
    logic        tog = 1'b0;
    logic        ph = 1'b0;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          dseed = 1;
    int          last_hs = 0;
    int          first_gap = 0;
    bit          saw_idle = 0;
    bit          first_saw = 0;
    item_t       iq[$];
    item_t       rq[$];
    int          fi_log[$];

    assign m_ready = mr_en && (!tog || ph);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) ph <= ~ph;

    fft_twiddle_issuer #(
        .SIZE_DATA_FI(4),
        .DATA_FFT_SIZE(16),
        .MULT_LATENCY(L),
        .FIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stage(stage),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data_i(s_data_i),
        .s_data_q(s_data_q),
        .s_last(s_last),
        .mul_en(mul_en),
        .mul_data_i(mul_data_i),
        .mul_data_q(mul_data_q),
        .mul_fi_deg(mul_fi_deg),
        .mul_valid(mul_valid),
        .mul_res_i(mul_res_i),
        .mul_res_q(mul_res_q),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data_i(m_data_i),
        .m_data_q(m_data_q),
        .m_last(m_last),
        .busy(busy)
`ifdef FFT_ISSUER_LAST_CHECK_EN
        ,
        .err_frame(err_frame)
`endif
    );

    // multiplier stand-in: fixed latency L, result = (data_i + fi, data_q ^ fi)
    logic        p_v [L];
    logic [15:0] p_i [L];
    logic [15:0] p_q [L];
    always @(posedge clk) begin
        p_v[0] <= mul_en;
        p_i[0] <= mul_data_i + mul_fi_deg;
        p_q[0] <= mul_data_q ^ mul_fi_deg;
        for (int i = 1; i < L; i++) begin
            p_v[i] <= p_v[i-1];
            p_i[i] <= p_i[i-1];
            p_q[i] <= p_q[i-1];
        end
    end
    assign mul_valid = p_v[L-1] === 1'b1;
    assign mul_res_i = p_i[L-1];
    assign mul_res_q = p_q[L-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    always @(negedge clk) begin : cmp
        item_t       it;
        logic [15:0] e_i;
        logic [15:0] e_q;
        logic        hold_v;
        logic [32:0] hold_d;
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (!busy) saw_idle = 1;
            if (mul_en) begin
                if (iq.size() == 0) fail_now("spurious_mul_en");
                else begin
                    it = iq.pop_front();
                    chk("issue_i", mul_data_i, it.d_i);
                    chk("issue_q", mul_data_q, it.d_q);
                    chk("issue_fi", mul_fi_deg, it.fi);
                    chk("issue_cycle", cyc, it.hs + 1);
                    fi_log.push_back(int'(mul_fi_deg));
                end
            end
            if (m_valid && hold_v) chk("m_stable", {m_data_i, m_data_q, m_last}, hold_d);
            if (m_valid && m_ready) begin
                if (rq.size() == 0) fail_now("spurious_m_valid");
                else begin
                    it  = rq.pop_front();
                    e_i = it.d_i + it.fi;
                    e_q = it.d_q ^ it.fi;
                    chk("out_i", m_data_i, e_i);
                    chk("out_q", m_data_q, e_q);
                    chk("out_last", m_last, it.last);
                    if (it.lat) chk("latency", cyc - it.hs, L + 2);
                end
            end
            hold_v = m_valid && !m_ready;
            hold_d = {m_data_i, m_data_q, m_last};
        end
    end

    task automatic send(input logic [3:0] stg, input int n, input int last_at, input bit lat);
        item_t it;
        int    w;
        for (int j = 0; j < n; j++) begin
            @(posedge clk); #1;
            s_valid  = 1'b1;
            stage    = stg;
            s_data_i = 16'(dseed * 311 + 165);
            s_data_q = 16'(dseed * 689) ^ 16'h5A5A;
            s_last   = (j == last_at);
            dseed++;
            w = 0;
            while (!s_ready && w < 200) begin
                @(posedge clk); #1;
                w++;
            end
            if (!s_ready) begin
                fail_now("s_ready_timeout");
                return;
            end
            if (j == 0) begin
                first_saw = saw_idle;
                first_gap = cyc - last_hs;
            end
            last_hs = cyc;
            it.d_i  = s_data_i;
            it.d_q  = s_data_q;
            it.fi   = 16'((j << stg) % HALF);
            it.last = (j == HALF - 1);
            it.hs   = cyc;
            it.lat  = lat;
            iq.push_back(it);
            rq.push_back(it);
        end
    endtask

    task automatic idle_in();
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((rq.size() != 0 || busy) && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain_busy", busy, 0);
        chk("drain_queue", rq.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int exp2[8] = '{0, 4, 0, 4, 0, 4, 0, 4};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_mul_en", mul_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_data_i", mul_data_i, 0);
        chk("rst_mul_data_q", mul_data_q, 0);
        chk("rst_mul_fi", mul_fi_deg, 0);
        reset = 1'b0;
        repeat (L + 1) @(posedge clk);

        fi_log.delete();
        send(4'd0, 8, 7, 1);
        idle_in();
        wait_drain();
        chk("s0_fi_count", fi_log.size(), 8);
        for (int i = 0; i < 8 && i < fi_log.size(); i++) chk("s0_fi_seq", fi_log[i], i);

        fi_log.delete();
        send(4'd2, 8, 7, 1);
        idle_in();
        wait_drain();
        chk("s2_fi_count", fi_log.size(), 8);
        for (int i = 0; i < 8 && i < fi_log.size(); i++) chk("s2_fi_seq", fi_log[i], exp2[i]);

        send(4'd5, 8, 7, 1);
        idle_in();
        wait_drain();

        mr_en = 1'b0;
        begin
            int t0 = cyc;
            send(4'd1, 8, 7, 0);
            idle_in();
            chk("stall_s_ready_low", s_ready, 0);
            chk("stall_accepted", rq.size(), 8);
            while (cyc - t0 < 20) begin
                @(posedge clk); #1;
            end
            chk("stall_m_valid", m_valid, 1);
            chk("stall_s_ready_held", s_ready, 0);
        end
        mr_en = 1'b1;
        wait_drain();

        tog = 1'b1;
        send(4'd1, 8, 7, 0);
        idle_in();
        wait_drain();
        tog = 1'b0;

        send(4'd0, 8, 7, 1);
        saw_idle = 0;
        send(4'd3, 8, 7, 1);
        idle_in();
        wait_drain();
        chk("b2b_idle_between", first_saw, 1);
        chk("b2b_gap_min", first_gap > L + 2, 1);

        send(4'd0, 3, 7, 0);
        idle_in();
        @(posedge clk); #1;
        reset = 1'b1;
        iq.delete();
        rq.delete();
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_mul_en", mul_en, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (L + 2) begin
            @(posedge clk); #1;
            chk("postrst_m_valid", m_valid, 0);
            chk("postrst_busy", busy, 0);
        end
        fi_log.delete();
        send(4'd0, 8, 7, 1);
        idle_in();
        wait_drain();
        chk("postrst_fi_count", fi_log.size(), 8);
        if (fi_log.size() > 0) chk("postrst_first_k", fi_log[0], 0);

`ifdef FFT_ISSUER_LAST_CHECK_EN
        chk("err_clean", err_frame, 0);
`endif
        send(4'd0, 8, 5, 1);
        idle_in();
        wait_drain();
`ifdef FFT_ISSUER_LAST_CHECK_EN
        chk("err_set", err_frame, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("err_sticky", err_frame, 1);
        reset = 1'b1;
        #1;
        chk("err_cleared", err_frame, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (L + 1) @(posedge clk);
`endif

        chk("final_iq_empty", iq.size(), 0);
        chk("final_rq_empty", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
